// File: rtl/stream_mux_n_1.sv
// N-to-1 valid/ready stream multiplexer with a single registered output slot.
// Arbitration is fixed-priority (mode 0) or round-robin from a rotating pointer (mode 1).
module stream_mux_n_1 #(
  parameter int unsigned width    = 8,
  parameter int unsigned channels = 4,
  parameter int unsigned mode     = 0
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [channels*width-1:0]                     in_data,
  input  logic [channels-1:0]                           in_valid,
  output logic [channels-1:0]                           in_ready,
  output logic [width-1:0]                              out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((channels > 1) ? $clog2(channels) : 1)-1:0] out_chan
);

  localparam int unsigned CW = (channels > 1) ? $clog2(channels) : 1;

  logic [width-1:0]    r_data;
  logic [CW-1:0]       r_chan;
  logic                r_valid;
  logic [CW-1:0]       r_ptr;

  logic                w_any;
  logic [CW-1:0]       w_gidx;
  logic [channels-1:0] w_grant;
  logic [width-1:0]    w_sel;
  logic                w_free;
  logic                w_fire;
  int unsigned         w_idx;

  // Search starts at the pointer in round-robin mode, at channel 0 otherwise.
  always_comb begin
    w_any   = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    w_grant = '0;
    w_sel   = '0;
    for (int unsigned k = 0; k < channels; k++) begin
      w_idx = (mode == 1) ? ((32'(r_ptr) + k) % channels) : k;
      if (!w_any && in_valid[CW'(w_idx)]) begin
        w_any  = 1'b1;
        w_gidx = CW'(w_idx);
      end
    end
    for (int unsigned i = 0; i < channels; i++) begin
      if (w_any && (w_gidx == CW'(i))) begin
        w_grant[i] = 1'b1;
        w_sel      = in_data[i*width +: width];
      end
    end
  end

  assign w_free   = !r_valid || out_ready;
  assign w_fire   = w_any && w_free && !reset;
  assign in_ready = (reset || !w_free) ? '0 : w_grant;

  // Output slot: reload on accept (even while draining), empty on drain-only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_data  <= w_sel;
      r_chan  <= w_gidx;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Pointer advances past the served channel; pinned at 0 in fixed-priority mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if ((mode == 1) && w_fire) begin
      if (32'(w_gidx) == channels - 1) r_ptr <= '0;
      else                             r_ptr <= w_gidx + CW'(1);
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Scoreboard bench: both arbitration modes driven in parallel; a reference model
// predicts grants and queues expected words, a negedge monitor checks the outputs.
module tb_stream_mux_n_1;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  od0, od1;
  logic        ov0, ov1;
  logic [1:0]  oc0, oc1;

  stream_mux_n_1 #(.width(8), .channels(4), .mode(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .out_chan(oc0)
  );

  stream_mux_n_1 #(.width(8), .channels(4), .mode(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .out_chan(oc1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
  } word_t;

  word_t q0[$], q1[$];
  word_t last0, last1;
  int    ptr1;
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting channel scanning from the start point.
  function automatic int pick(input int rr, input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = rr ? (p + k) % N : k;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus: drive, check in_ready, predict transfers, advance.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int    g0, g1;
    bit    a0, a1;
    word_t w0, w1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    g0 = pick(0, v, 0);
    g1 = pick(1, v, ptr1);
    a0 = (g0 >= 0) && (q0.size() == 0 || ordy);
    a1 = (g1 >= 0) && (q1.size() == 0 || ordy);
    chk("in_ready_fp", 32'(rdy0), a0 ? (32'd1 << g0) : 32'd0);
    chk("in_ready_rr", 32'(rdy1), a1 ? (32'd1 << g1) : 32'd0);
    w0 = '0;
    w1 = '0;
    if (a0) begin w0.d = d[g0*8 +: 8]; w0.c = 2'(g0); end
    if (a1) begin w1.d = d[g1*8 +: 8]; w1.c = 2'(g1); end
    @(posedge clk);
    if (a0) begin q0.push_back(w0); last0 = w0; end
    if (a1) begin q1.push_back(w1); last1 = w1; ptr1 = (g1 + 1) % N; end
    #1;
  endtask

  // Reset between edges; outputs must clear at once without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    ptr1  = 0;
    #1;
    chk("rst_valid_fp", 32'(ov0), 32'd0);
    chk("rst_data_fp",  32'(od0), 32'd0);
    chk("rst_chan_fp",  32'(oc0), 32'd0);
    chk("rst_ready_fp", 32'(rdy0), 32'd0);
    chk("rst_valid_rr", 32'(ov1), 32'd0);
    chk("rst_data_rr",  32'(od1), 32'd0);
    chk("rst_ready_rr", 32'(rdy1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: output slot must mirror the scoreboard head; pop on downstream accept.
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_fp", 32'(ov0), 32'(q0.size() != 0));
      chk("data_fp",  32'(od0), 32'(last0.d));
      chk("chan_fp",  32'(oc0), 32'(last0.c));
      if (q0.size() != 0) chk("head_fp", 32'(od0), 32'(q0[0].d));
      if (q0.size() != 0 && out_ready) void'(q0.pop_front());
      chk("valid_rr", 32'(ov1), 32'(q1.size() != 0));
      chk("data_rr",  32'(od1), 32'(last1.d));
      chk("chan_rr",  32'(oc1), 32'(last1.c));
      if (q1.size() != 0) chk("head_rr", 32'(od1), 32'(q1[0].d));
      if (q1.size() != 0 && out_ready) void'(q1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b0;
    ptr1      = 0;
    do_reset();

    // Fixed priority picks ch1 out of 1010 every cycle.
    for (int i = 0; i < 3; i++) cycle(4'b1010, $urandom, 1'b1);

    // Round-robin rotation with all channels requesting.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(4'b1111, $urandom, 1'b1);

    // Round-robin skip and wrap: ptr to 3, then 0101 serves ch0 then ch2.
    do_reset();
    cycle(4'b0100, $urandom, 1'b1);
    cycle(4'b0101, $urandom, 1'b1);
    cycle(4'b0101, $urandom, 1'b1);

    // Backpressure with 0x3C from ch2 held, then consume and reload same edge.
    do_reset();
    cycle(4'b0100, 32'h003C_0000, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b1111, $urandom, 1'b0);
    cycle(4'b1111, $urandom, 1'b1);
    cycle(4'b0000, $urandom, 1'b1);

    // Drain: one word, then idle; data must be retained after valid drops.
    do_reset();
    cycle(4'b0001, 32'h0000_0077, 1'b1);
    cycle(4'b0000, $urandom, 1'b1);
    cycle(4'b0000, $urandom, 1'b1);

    // Reset with a FULL slot holding 0xA5.
    cycle(4'b0001, 32'h0000_00A5, 1'b0);
    cycle(4'b1111, $urandom, 1'b0);
    do_reset();

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end
    cycle(4'b0000, $urandom, 1'b1);
    cycle(4'b0000, $urandom, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
